// File: rtl/bram_pixel_streamer_pkg.sv
// deconv_pkg: shared state encoding and word/pixel sizing helpers for the BRAM pixel streamer
package deconv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int pix_per_word(int bram_w, int pix_w);
    return bram_w / pix_w;
  endfunction
  function automatic int words_for(int num_pix, int ppw);
    return (num_pix + ppw - 1) / ppw;
  endfunction
endpackage

// File: rtl/bram_pixel_streamer_if.sv
// bram_pixel_streamer_if: request, pixel-stream and BRAM read-port signals of one streamer lane
//   master: the streamer (drives status, pixel stream and BRAM address/enable)
//   slave : the host/consumer/BRAM side
interface bram_pixel_streamer_if #(
  parameter int ADDRESS_WIDTH   = 13,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int PIX_WIDTH       = 16,
  parameter int COUNT_WIDTH     = 16
);
  logic                       i_start;
  logic [ADDRESS_WIDTH-1:0]   i_base_addr;
  logic [COUNT_WIDTH-1:0]     i_num_pix;
  logic                       o_busy;
  logic                       o_done;
  logic                       i_rd_en;
  logic                       o_rd_valid;
  logic [PIX_WIDTH-1:0]       o_rd_data;
  logic [ADDRESS_WIDTH-1:0]   bram_addr;
  logic                       bram_en;
  logic                       bram_we;
  logic [BRAM_DATA_WIDTH-1:0] bram_data_out;
  modport master (
    input  i_start, i_base_addr, i_num_pix, i_rd_en, bram_data_out,
    output o_busy, o_done, o_rd_valid, o_rd_data, bram_addr, bram_en, bram_we
  );
  modport slave (
    output i_start, i_base_addr, i_num_pix, i_rd_en, bram_data_out,
    input  o_busy, o_done, o_rd_valid, o_rd_data, bram_addr, bram_en, bram_we
  );
endinterface

// File: rtl/bram_pixel_streamer_fifo.sv
// pix_word_fifo: synchronous FIFO of BRAM words with occupancy count
//   i_clk/i_rst_n clock and async active-low reset; push/wdata write; pop read; rdata head word; count occupancy
module pix_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wptr_d  = push ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d  = pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge i_clk)
    if (push) mem_q[wptr_q] <= wdata;
  assign rdata = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/bram_pixel_streamer.sv
// bram_pixel_streamer: fetches a run of BRAM words and streams their pixels one per cycle
//   i_clk, i_rst_n (async active-low); sif.master carries start/base/count request, busy/done status,
//   rd_en/rd_valid/rd_data pixel stream and the read-only BRAM port
module bram_pixel_streamer
  import deconv_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 13,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int PIX_WIDTH       = 16,
  parameter int BRAM_LATENCY    = 1,
  parameter int COUNT_WIDTH     = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  bram_pixel_streamer_if.master sif
);
  localparam int PPW   = pix_per_word(BRAM_DATA_WIDTH, PIX_WIDTH);
  localparam int LW    = PPW > 1 ? $clog2(PPW) : 1;
  localparam int DEPTH = BRAM_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d, pix_q, pix_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [BRAM_LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0] fifo_count, in_flight;
  logic [BRAM_DATA_WIDTH-1:0] head;
  logic valid, xfer, last, pop, issue;
  assign valid = fifo_count != '0;
  pix_word_fifo #(.WIDTH(BRAM_DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(pipe_q[BRAM_LATENCY-1]), .wdata(sif.bram_data_out),
    .pop(pop), .rdata(head), .count(fifo_count)
  );
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) in_flight = in_flight + CW'(pipe_q[i]);
    xfer  = valid && sif.i_rd_en;
    last  = pix_q == COUNT_WIDTH'(1);
    // the final pixel also pops, discarding unused lanes of a partial last word
    pop   = xfer && (lane_q == LW'(PPW - 1) || last);
    // credit: buffered + in-flight words, net of this cycle's pop, must leave room in the FIFO
    issue = state_q == RUN && words_q != '0 && int'(fifo_count) + int'(in_flight) - int'(pop) < DEPTH;
    pipe_d  = BRAM_LATENCY'({pipe_q, issue});
    state_d = state_q;
    addr_d  = issue ? addr_q + 1'b1 : addr_q;
    words_d = issue ? words_q - 1'b1 : words_q;
    pix_d   = xfer ? pix_q - 1'b1 : pix_q;
    lane_d  = pop ? '0 : xfer ? lane_q + 1'b1 : lane_q;
    if (state_q == IDLE && sif.i_start) begin
      state_d = sif.i_num_pix == '0 ? DONE : RUN;
      addr_d  = sif.i_base_addr;
      words_d = COUNT_WIDTH'(words_for(int'(sif.i_num_pix), PPW));
      pix_d   = sif.i_num_pix;
      lane_d  = '0;
    end else if (state_q == RUN && xfer && last) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      pix_q   <= '0;
      lane_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      pix_q   <= pix_d;
      lane_q  <= lane_d;
      pipe_q  <= pipe_d;
    end
  assign sif.o_busy     = state_q == RUN;
  assign sif.o_done     = state_q == DONE;
  assign sif.o_rd_valid = valid;
  assign sif.o_rd_data  = valid ? PIX_WIDTH'(head >> (lane_q * PIX_WIDTH)) : '0;
  assign sif.bram_en    = issue;
  assign sif.bram_addr  = addr_q;
  assign sif.bram_we    = 1'b0;
endmodule

// File: tb/tb_bram_pixel_streamer.sv
// tb_bram_pixel_streamer: scoreboard bench with a registered BRAM model and a pixel/address reference model
module tb_bram_pixel_streamer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  bram_pixel_streamer_if #(.ADDRESS_WIDTH(13), .BRAM_DATA_WIDTH(32), .PIX_WIDTH(16), .COUNT_WIDTH(16)) sif ();
  bram_pixel_streamer #(.ADDRESS_WIDTH(13), .BRAM_DATA_WIDTH(32), .PIX_WIDTH(16), .BRAM_LATENCY(1), .COUNT_WIDTH(16))
    dut (.i_clk(clk), .i_rst_n(rst_n), .sif(sif));
  logic [31:0] mem [8192];
  logic [15:0] pix_exp [$];
  logic [12:0] addr_exp [$];
  int n_pass = 0, n_total = 0, cyc = 0, done_seen = 0, last_xfer = 0, mode = 0;
  bit expect_timing = 0, prev_stall = 0;
  logic [15:0] prev_data, e_pix;
  logic [12:0] e_addr;
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask
  initial for (int a = 0; a < 8192; a++) mem[a] = {16'(2 * a + 1), 16'(2 * a)};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sif.bram_en) sif.bram_data_out <= mem[sif.bram_addr];
  end
  always @(posedge clk) begin
    int k;
    #1;
    sif.i_rd_en = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
    k++;
  end
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) chk(sif.o_rd_valid && sif.o_rd_data == prev_data, "stall_hold", sif.o_rd_data, prev_data);
      if (sif.bram_en) begin
        chk(!sif.bram_we, "bram_we", sif.bram_we, 0);
        if (addr_exp.size() == 0) chk(0, "extra_read", sif.bram_addr, 0);
        else begin
          e_addr = addr_exp.pop_front();
          chk(sif.bram_addr == e_addr, "bram_addr", sif.bram_addr, e_addr);
        end
      end
      if (sif.o_rd_valid && sif.i_rd_en) begin
        if (pix_exp.size() == 0) chk(0, "extra_pixel", sif.o_rd_data, 0);
        else begin
          e_pix = pix_exp.pop_front();
          chk(sif.o_rd_data == e_pix, "pixel", sif.o_rd_data, e_pix);
          if (pix_exp.size() == 0) last_xfer = cyc;
        end
      end
      if (sif.o_done) begin
        done_seen++;
        chk(!sif.o_busy && pix_exp.size() == 0 && addr_exp.size() == 0, "done_state", pix_exp.size(), 0);
        if (expect_timing) chk(cyc == last_xfer + 1, "done_timing", cyc, last_xfer + 1);
      end
      prev_stall = sif.o_rd_valid && !sif.i_rd_en;
      prev_data  = sif.o_rd_data;
    end
  end
  task automatic expect_run(input int base, input int num);
    for (int p = 0; p < num; p++) pix_exp.push_back(16'(2 * ((base + p / 2) % 8192) + p % 2));
    for (int w = 0; w < (num + 1) / 2; w++) addr_exp.push_back(13'((base + w) % 8192));
    expect_timing = num > 0;
  endtask
  task automatic run(input int base, input int num, input bit interfere);
    int d0, t;
    expect_run(base, num);
    d0 = done_seen;
    sif.i_base_addr = 13'(base);
    sif.i_num_pix = 16'(num);
    sif.i_start = 1;
    @(posedge clk);
    @(negedge clk);
    sif.i_start = 0;
    chk(sif.o_busy == (num > 0), "busy_after_start", sif.o_busy, num > 0);
    chk(sif.bram_en == (num > 0), "first_read", sif.bram_en, num > 0);
    chk(sif.o_done == (num == 0), "zero_done", sif.o_done, num == 0);
    if (num > 0) begin
      @(negedge clk);
      chk(!sif.o_rd_valid, "early_valid", sif.o_rd_valid, 0);
      @(negedge clk);
      chk(sif.o_rd_valid, "first_valid", sif.o_rd_valid, 1);
      if (interfere) begin
        sif.i_base_addr = 13'd500;
        sif.i_num_pix = 16'd3;
        sif.i_start = 1;
        @(negedge clk);
        sif.i_start = 0;
      end
    end
    t = 0;
    while (done_seen == d0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk(done_seen == d0 + 1, "done_count", done_seen - d0, 1);
    @(negedge clk);
    chk(!sif.o_done && !sif.o_busy && !sif.o_rd_valid, "done_pulse", {sif.o_done, sif.o_busy, sif.o_rd_valid}, 0);
  endtask
  initial begin
    sif.i_start = 0;
    sif.i_base_addr = '0;
    sif.i_num_pix = '0;
    repeat (3) @(negedge clk);
    chk({sif.o_busy, sif.o_done, sif.o_rd_valid, sif.bram_en, sif.bram_we} == 0 && sif.o_rd_data == 0 && sif.bram_addr == 0,
        "reset_state", {sif.o_busy, sif.o_done, sif.o_rd_valid, sif.bram_en}, 0);
    rst_n = 1;
    @(negedge clk);
    run(10, 4, 0);
    run(10, 3, 0);
    mode = 1;
    run(0, 8, 0);
    mode = 0;
    run(0, 0, 0);
    run(8190, 6, 0);
    expect_run(0, 20);
    sif.i_base_addr = '0;
    sif.i_num_pix = 16'd20;
    sif.i_start = 1;
    @(posedge clk);
    @(negedge clk);
    sif.i_start = 0;
    repeat (6) @(negedge clk);
    rst_n = 0;
    #1;
    chk({sif.o_busy, sif.o_done, sif.o_rd_valid, sif.bram_en} == 0 && sif.o_rd_data == 0,
        "reset_midrun", {sif.o_busy, sif.o_done, sif.o_rd_valid, sif.bram_en}, 0);
    pix_exp.delete();
    addr_exp.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, 2, 0);
    run(100, 6, 1);
    for (int r = 0; r < 20; r++) begin
      mode = $urandom_range(0, 2);
      run($urandom_range(0, 8191), $urandom_range(0, 24), r[0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bram_pixel_streamer.md
Name: bram_pixel_streamer

Overview:
Upstream read engine that feeds one lane of the deconv_core reader inputs (weight or feature). It fetches a contiguous run of BRAM_DATA_WIDTH words from one single-port BRAM, unpacks each word into PIX_WIDTH pixels, and presents them one pixel per cycle on a valid/enable handshake. Four instances, one per BRAM, drive the 4-lane weight_reader_* / feature_reader_* buses. Read-only: the write path is out of scope.

Parameters:
ADDRESS_WIDTH, 13, BRAM word address width
BRAM_DATA_WIDTH, 32, BRAM word width; integer multiple of PIX_WIDTH
PIX_WIDTH, 16, pixel width
BRAM_LATENCY, 1, BRAM read latency in cycles (1 or 2)
COUNT_WIDTH, 16, width of the pixel-count request field

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_start  in  1  request pulse; sampled only in IDLE
i_base_addr  in  ADDRESS_WIDTH  first word address
i_num_pix  in  COUNT_WIDTH  pixels to stream
o_busy  out  1  high from accepted start until the done cycle
o_done  out  1  one-cycle pulse after the last pixel is consumed
i_rd_en  in  1  consumer ready; pixel transfers when i_rd_en && o_rd_valid
o_rd_valid  out  1  o_rd_data holds a valid pixel
o_rd_data  out  PIX_WIDTH  current pixel
bram_addr  out  ADDRESS_WIDTH  BRAM address
bram_en  out  1  BRAM enable, one cycle per word read
bram_we  out  1  tied 0
bram_data_out  in  BRAM_DATA_WIDTH  BRAM douta

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; buffer empty; in-flight reads discarded.
- PPW = BRAM_DATA_WIDTH/PIX_WIDTH. Pixel p maps to word i_base_addr + p/PPW, lane p%PPW; lane 0 = bits [PIX_WIDTH-1:0].
- NWORDS = ceil(i_num_pix/PPW). Address increments mod 2^ADDRESS_WIDTH, so a run past the top wraps to 0.
- States:
  - IDLE: i_start=1 and i_num_pix>0 latches base/count and goes to RUN. i_start=1 with i_num_pix=0 goes to DONE; no BRAM access.
  - RUN: issues reads. Goes to DONE on the cycle the last pixel transfers.
  - DONE: o_done=1 and o_busy=0 for one cycle, then IDLE.
- i_start outside IDLE is ignored.
- Read issue: bram_en=1 with bram_addr when words_remaining>0 and (buffer_count + in_flight − pop_this_cycle) < BRAM_LATENCY+1.
- Word buffer: FIFO of depth BRAM_LATENCY+1. It captures bram_data_out BRAM_LATENCY cycles after each bram_en and can never overflow under the credit rule above.
- Output side: o_rd_valid = buffer non-empty. o_rd_data = lane lane_idx of the head word.
  - On transfer, lane_idx increments.
  - Head pops at lane PPW−1 or at the final pixel; a partial last word drops its unused lanes.
- o_rd_data and o_rd_valid are stable while o_rd_valid && !i_rd_en.
- Latency and throughput:
  - Start sampled at edge E → bram_en high during cycle E..E+1.
  - First o_rd_valid after edge E+1+BRAM_LATENCY.
  - Sustained 1 pixel/cycle with i_rd_en held high; no bubbles.
- Reset mid-run: immediate return to IDLE, o_rd_valid=0, no o_done. The next i_start behaves as from power-up.

Decomposition:
- Shared package deconv_pkg:
  - state enum (IDLE, RUN, DONE)
  - function pix_per_word(BRAM_DATA_WIDTH, PIX_WIDTH)
  - function words_for(num_pix, ppw)
- One natural sub-module: pix_word_fifo, a parameterised-depth synchronous FIFO with count output used for credit.

Test Plan:
BRAM preloaded with word[a] = {16'(2a+1),16'(2a)}.
1. base=10, num=4, i_rd_en=1 → o_rd_data 0x0014,0x0015,0x0016,0x0017 on 4 consecutive valid cycles; bram_en exactly 2 cycles (addr 10,11); o_done one cycle after last transfer.
2. base=10, num=3 → pixels 0x0014,0x0015,0x0016; 2 word reads; no 4th pixel; o_done pulses.
3. base=0, num=8, i_rd_en toggling 1,0,0,1,... → 0x0000..0x0007 in order, none lost or duplicated; data stable during stalls; buffer never exceeds BRAM_LATENCY+1.
4. num=0 start → o_done high next cycle, bram_en never asserted, o_rd_valid stays 0.
5. base=8190 (ADDRESS_WIDTH=13), num=6 → reads addresses 8190, 8191, 0; pixels follow the wrap.
6. Reset asserted mid-run of num=20 → outputs 0 immediately; then start base=0, num=2 → 0x0000,0x0001, o_done. A second i_start while busy → ignored, no extra reads.
